// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise controller slice.
// Contents: cruise FSM state encodings, minimum engage speed, repeat FSM
// state type and the button priority indices (lower index = higher priority).
package cruise_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b1000,
    DEFAULT = 4'b0001,
    CRUISE  = 4'b0010,
    BRAKE   = 4'b0100
  } cruise_state_t;

  localparam logic [31:0] SET_MIN_SPEED = 32'd45;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } repeat_state_t;

  // Button vector order doubles as the arbitration priority.
  localparam int unsigned PRI_CANCEL = 0;
  localparam int unsigned PRI_RESUME = 1;
  localparam int unsigned PRI_SET    = 2;
  localparam int unsigned PRI_ACCEL  = 3;
  localparam int unsigned PRI_COAST  = 4;
  localparam int unsigned NUM_BTN    = 5;

endpackage

// File: rtl/cruise_button_panel_debouncer.sv
// button_debouncer: 2-flop synchroniser, stability counter, stable level
// register and rising-edge pulse for one raw button.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high
//   raw    in   asynchronous button level
//   stable out  debounced level
//   rise   out  one-cycle pulse on a rising edge of stable
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_q;
  logic          stable_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync     <= '0;
      cnt      <= '0;
      stable_q <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      stable_d <= stable_q;
      if (sync[1] != stable_q) begin
        // The cycle that would make cnt reach DEBOUNCE_CYCLES accepts the level.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= sync[1];
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_d;

endmodule

// File: rtl/cruise_button_panel.sv
// cruise_button_panel: conditions steering-wheel buttons and pedals into
// registered command pulses for the cruise FSM.
// Ports:
//   clock, reset (sync, active-high)
//   btn_set/accel/coast/cancel/resume  raw buttons, high = pressed
//   pedal_brake, pedal_throttle        raw pedal switches
//   cruise_status, speed[31:0]         fed back from the cruise FSM
//   set/accel/coast/cancel/resume      one-cycle command pulses (one-hot or none)
//   brake, throttle                    synchronised pedal levels
//   cmd_reject                         pulse: an accepted press was dropped
// Build option: define AUTO_REPEAT_EN to enable accel/coast auto-repeat.
module cruise_button_panel
  import cruise_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_set,
  input  logic        btn_accel,
  input  logic        btn_coast,
  input  logic        btn_cancel,
  input  logic        btn_resume,
  input  logic        pedal_brake,
  input  logic        pedal_throttle,
  input  logic        cruise_status,
  input  logic [31:0] speed,
  output logic        set,
  output logic        accel,
  output logic        coast,
  output logic        cancel,
  output logic        resume,
  output logic        brake,
  output logic        throttle,
  output logic        cmd_reject
);

  logic [1:0]         brake_sync;
  logic [1:0]         throttle_sync;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] cmd_next;
  logic [NUM_BTN-1:0] cmd_q;
  logic               reject_next;
  logic               reject_q;
  logic               found;
  logic               lose;
  logic               allowed;
  logic               issued;
  logic [2:0]         win_idx;
  logic [2:0]         rep_idx;
  logic               repeat_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      brake_sync    <= '0;
      throttle_sync <= '0;
    end else begin
      brake_sync    <= {brake_sync[0], pedal_brake};
      throttle_sync <= {throttle_sync[0], pedal_throttle};
    end
  end

  assign btn_raw[PRI_CANCEL] = btn_cancel;
  assign btn_raw[PRI_RESUME] = btn_resume;
  assign btn_raw[PRI_SET]    = btn_set;
  assign btn_raw[PRI_ACCEL]  = btn_accel;
  assign btn_raw[PRI_COAST]  = btn_coast;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (btn_raw[g]),
      .stable(btn_level[g]),
      .rise  (rise[g])
    );
  end

  always_comb begin
    found   = 1'b0;
    lose    = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (rise[i]) begin
        if (found) begin
          lose = 1'b1;
        end else begin
          found   = 1'b1;
          win_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    if (win_idx == 3'(PRI_SET)) begin
      allowed = !cruise_status && (speed >= SET_MIN_SPEED);
    end else if (win_idx == 3'(PRI_RESUME)) begin
      allowed = !cruise_status;
    end else begin
      allowed = cruise_status;
    end
    allowed = allowed && !brake_sync[1];
  end

  assign issued = found && allowed;

  // A fresh press always takes the slot; a due repeat is dropped without reject.
  always_comb begin
    cmd_next = '0;
    if (issued) begin
      cmd_next[win_idx] = 1'b1;
    end else if (!found && repeat_fire) begin
      cmd_next[rep_idx] = 1'b1;
    end
    reject_next = lose || (found && !allowed);
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned TMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW = $clog2(TMAX + 1);

  repeat_state_t state;
  repeat_state_t state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          rep_coast;
  logic          rep_coast_next;
  logic          held;
  logic          abort;

  assign rep_idx     = rep_coast ? 3'(PRI_COAST) : 3'(PRI_ACCEL);
  assign held        = btn_level[rep_idx];
  assign abort       = !held || brake_sync[1] || !cruise_status;
  // Firing on timer==1 makes the pulse register on the edge the timer hits 0.
  assign repeat_fire = (state != R_IDLE) && (timer == TW'(1)) && !abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= R_IDLE;
      timer     <= '0;
      rep_coast <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      rep_coast <= rep_coast_next;
    end
  end

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    rep_coast_next = rep_coast;
    if (state != R_IDLE) begin
      timer_next = timer - TW'(1);
    end
    if (issued) begin
      if (win_idx == 3'(PRI_ACCEL) || win_idx == 3'(PRI_COAST)) begin
        state_next     = R_DELAY;
        timer_next     = TW'(REPEAT_DELAY);
        rep_coast_next = (win_idx == 3'(PRI_COAST));
      end else begin
        state_next = R_IDLE;
      end
    end else if (state != R_IDLE && abort) begin
      state_next = R_IDLE;
    end else if (repeat_fire) begin
      state_next = R_REPEAT;
      timer_next = TW'(REPEAT_PERIOD);
    end
  end
`else
  localparam int unsigned repeat_cfg_unused = REPEAT_DELAY + REPEAT_PERIOD;
  logic [NUM_BTN-1:0] level_unused;

  assign level_unused = btn_level;
  assign repeat_fire  = 1'b0;
  assign rep_idx      = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      cmd_q    <= cmd_next;
      reject_q <= reject_next;
    end
  end

  assign cancel     = cmd_q[PRI_CANCEL];
  assign resume     = cmd_q[PRI_RESUME];
  assign set        = cmd_q[PRI_SET];
  assign accel      = cmd_q[PRI_ACCEL];
  assign coast      = cmd_q[PRI_COAST];
  assign cmd_reject = reject_q;
  assign brake      = brake_sync[1];
  assign throttle   = throttle_sync[1];

endmodule
